// File: rtl/noc_pe_rx_sink.sv
// Receive-side NoC endpoint: checks destination and per-source sequence, buffers payloads in a FIFO.
// Optional latency statistics are compiled in when RX_LATENCY_EN is defined.
module noc_pe_rx_sink #(
  parameter int X           = 2,
  parameter int Y           = 2,
  parameter int x_size      = $clog2(X),
  parameter int y_size      = $clog2(Y),
  parameter int data_width  = 256,
  parameter int MY_X        = 0,
  parameter int MY_Y        = 0,
  parameter int EXPECT_PKTS = 1000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                w_valid_pe,
  input  logic [x_size+y_size+data_width-1:0] w_data_pe,
  input  logic [31:0]                         cycle_now,
  output logic                                o_valid,
  output logic [data_width-1:0]               o_data,
  input  logic                                o_ready,
  output logic [31:0]                         rx_count,
  output logic                                err_addr,
  output logic                                err_seq,
  output logic                                overflow,
  output logic                                done,
  output logic [31:0]                         lat_max,
  output logic [47:0]                         lat_sum
);

  localparam int PW  = x_size + y_size + data_width;
  localparam int NPE = X * Y;
  localparam int SW  = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  function automatic logic [31:0] sat_inc32(input logic [31:0] a);
    return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
  endfunction

  // Stage 1: raw capture of the router local port
  logic          r_vld_p1, r_vld_p2;
  logic [PW-1:0] r_data_p1, r_data_p2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_valid_pe;
      r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_data_p1 <= w_data_pe;
    r_data_p2 <= r_data_p1;
  end

  // Stage 2: checks against the held packet; results land on the next edge
  logic [x_size-1:0]     w_xdst;
  logic [y_size-1:0]     w_ydst;
  logic [data_width-1:0] w_payload;
  logic [31:0]           w_ts;
  logic [15:0]           w_seq;
  logic [7:0]            w_src;
  logic [SW-1:0]         w_idx;
  logic                  w_addr_ok, w_src_ok, w_seq_bad;
  logic [31:0]           w_cnt_next;

  assign w_xdst     = r_data_p2[PW-1 -: x_size];
  assign w_ydst     = r_data_p2[data_width +: y_size];
  assign w_payload  = r_data_p2[data_width-1:0];
  assign w_ts       = w_payload[31:0];
  assign w_seq      = w_payload[47:32];
  assign w_src      = w_payload[55:48];
  assign w_idx      = w_src[SW-1:0];
  assign w_addr_ok  = (w_xdst == x_size'(MY_X)) && (w_ydst == y_size'(MY_Y));
  assign w_src_ok   = ({24'd0, w_src} < 32'(NPE));
  assign w_cnt_next = sat_inc32(rx_count);

  // Next expected sequence per source; resynchronises on every packet so one gap flags once
  logic [15:0] r_seq_tbl [NPE];

  assign w_seq_bad = !w_src_ok || (w_seq != r_seq_tbl[w_idx]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NPE; i++) r_seq_tbl[i] <= 16'd0;
    end else if (r_vld_p2 && w_src_ok) begin
      r_seq_tbl[w_idx] <= w_seq + 16'd1;
    end
  end

  // Output FIFO, pointers carry one extra wrap bit
  logic [data_width-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr, r_rd_ptr;
  logic                  w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && o_ready;
  assign w_push  = r_vld_p2 && (!w_full || w_pop);
  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_payload;
  end

  // Counters and sticky error flags
  logic [31:0] r_rx_count;
  logic        r_err_addr, r_err_seq, r_overflow, r_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_count <= 32'd0;
      r_err_addr <= 1'b0;
      r_err_seq  <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else if (r_vld_p2) begin
      r_rx_count <= w_cnt_next;
      if (!w_addr_ok)          r_err_addr <= 1'b1;
      if (w_seq_bad)           r_err_seq  <= 1'b1;
      if (w_full && !w_pop)    r_overflow <= 1'b1;
      if ((EXPECT_PKTS != 0) && (w_cnt_next == 32'(EXPECT_PKTS))) r_done <= 1'b1;
    end
  end

  assign rx_count = r_rx_count;
  assign err_addr = r_err_addr;
  assign err_seq  = r_err_seq;
  assign overflow = r_overflow;
  assign done     = r_done;

`ifdef RX_LATENCY_EN
  function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [31:0] b);
    logic [48:0] s;
    s = {1'b0, a} + {17'd0, b};
    return s[48] ? {48{1'b1}} : s[47:0];
  endfunction

  logic [31:0] w_lat;
  logic [31:0] r_lat_max;
  logic [47:0] r_lat_sum;

  assign w_lat = cycle_now - w_ts;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lat_max <= 32'd0;
      r_lat_sum <= 48'd0;
    end else if (r_vld_p2) begin
      if (w_lat > r_lat_max) r_lat_max <= w_lat;
      r_lat_sum <= sat_add48(r_lat_sum, w_lat);
    end
  end

  assign lat_max = r_lat_max;
  assign lat_sum = r_lat_sum;
`else
  logic w_unused_lat;
  assign w_unused_lat = ^{cycle_now, w_ts};
  assign lat_max      = 32'd0;
  assign lat_sum      = 48'd0;
`endif

endmodule
